// File: rtl/onehot_dec_pkg.sv
// Shared constants and decode helper for the binary <-> one-hot stream datapath.
// The encoder side imports the same package for its bit-width constants.
package onehot_dec_pkg;

  localparam int unsigned DEF_IN_W   = 2;
  localparam int unsigned DEF_OUT_W  = 4;
  localparam int unsigned DEF_CNT_W  = 8;
  localparam int unsigned DEF_WORD_W = DEF_OUT_W + 1;
  localparam int unsigned MAX_OUT_W  = 32;

  // Occupancy encoding of the two-entry buffer: bit0 = main full, bit1 = skid full.
  localparam logic [1:0] OCC_EMPTY = 2'b00;
  localparam logic [1:0] OCC_ONE   = 2'b01;
  localparam logic [1:0] OCC_FULL  = 2'b11;

  // Returns {onehot, err} with err in bit 0; callers truncate to out_w+1 bits.
  function automatic logic [MAX_OUT_W:0] to_onehot(input logic [31:0] code,
                                                   input int unsigned out_w);
    logic [MAX_OUT_W:0] word;
    if (code < out_w) word = {{MAX_OUT_W{1'b0}}, 1'b1} << (code + 32'd1);
    else              word = {{MAX_OUT_W{1'b0}}, 1'b1};
    return word;
  endfunction

endpackage

// File: rtl/onehot_decoder_stream_skid.sv
// Generic two-entry valid/ready skid register: a main output register plus one
// skid entry, with in_ready taken straight from a flop.
module skid_buffer_2
  import onehot_dec_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   occ_q, occ_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q;
  logic         push;

  assign push = in_valid && rdy_q;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned (no latch).
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      OCC_EMPTY: begin
        if (push) begin
          main_d = in_data;
          occ_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (out_ready) begin
          if (push) main_d = in_data;
          else      occ_d  = OCC_EMPTY;
        end else if (push) begin
          skid_d = in_data;
          occ_d  = OCC_FULL;
        end
      end
      OCC_FULL: begin
        // Oldest word is in main, so skid always refills main before any new word.
        if (out_ready) begin
          main_d = skid_q;
          if (push) skid_d = in_data;
          else      occ_d  = OCC_ONE;
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q  <= OCC_EMPTY;
      main_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
      rdy_q  <= (occ_d != OCC_FULL);
    end
  end

  // NOTE: skid data is only observed when its occupancy bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    skid_q <= skid_d;
  end

  assign in_ready  = rdy_q;
  assign out_valid = occ_q[0];
  assign out_data  = main_q;

endmodule

// File: rtl/onehot_decoder_stream.sv
// Streaming binary-to-one-hot decoder: combinational decode, two-entry skid
// storage of {onehot, err}, and a saturating count of accepted illegal codes.
module onehot_decoder_stream
  import onehot_dec_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned OUT_W = DEF_OUT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_onehot,
  output logic             out_err,
  output logic [CNT_W-1:0] err_count,
  input  logic             err_clr
);

  localparam int unsigned WORD_W = OUT_W + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (OUT_W < 1 || OUT_W > (2 ** IN_W) || OUT_W > MAX_OUT_W) begin : g_bad_out_w
    $error("onehot_decoder_stream: OUT_W must be in 1..2**IN_W");
  end

  logic [WORD_W-1:0] dec_word;
  logic [WORD_W-1:0] out_word;
  logic              accept;

  assign dec_word = WORD_W'(to_onehot(32'(in_code), OUT_W));
  assign accept   = in_valid && in_ready;

  skid_buffer_2 #(
    .W (WORD_W)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (dec_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_word)
  );

  assign out_onehot = out_word[WORD_W-1:1];
  assign out_err    = out_word[0];

  // Counted at acceptance, not at output, so the count is independent of backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (err_clr) begin
      err_count <= '0;
    end else if (accept && dec_word[0] && err_count != CNT_MAX) begin
      err_count <= err_count + 1'b1;
    end
  end

endmodule
